// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared types and helpers for the maze walker
// Contents: direction codes in probe order, walker states, maze geometry
// constants and the opposite-direction helper used when backtracking.
package maze_pkg;

  localparam int COORD_W     = 4;
  localparam int MAZE_DIM    = 16;
  localparam int STACK_DEPTH = 256;
  localparam int SP_W        = 9;

  localparam logic [COORD_W-1:0] COORD_MAX = COORD_W'(MAZE_DIM - 1);

  // Encoding doubles as the probe order and as the replayed move code.
  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_UP    = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARK,
    ST_PROBE,
    ST_ADVANCE,
    ST_BACKTRACK,
    ST_DONE,
    ST_FAIL,
    ST_SHOW
  } walk_state_t;

  // right<->left and down<->up differ only in bit 1.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/dir_stack.sv
// rtl/dir_stack.sv - 256 x 2-bit direction stack with replay read port
// Ports:
//   clk, rst          clock, asynchronous active-high reset (pointer only)
//   clear             empties the stack (wins over push/pop)
//   push, push_data   store push_data at the current count
//   pop               drop the top entry
//   top               entry at count-1 (valid while count > 0)
//   rd_addr, rd_data  random-access read for route replay
//   count             number of stored entries (0..256)
module dir_stack
  import maze_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            push,
  input  logic            pop,
  input  logic [1:0]      push_data,
  input  logic [7:0]      rd_addr,
  output logic [1:0]      top,
  output logic [1:0]      rd_data,
  output logic [SP_W-1:0] count
);

  logic [1:0] mem [STACK_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (push) begin
      count <= count + 9'd1;
    end else if (pop) begin
      count <= count - 9'd1;
    end
  end

  // Storage is deliberately left unreset; only entries below count are meaningful.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[count[7:0]] <= push_data;
    end
  end

  assign top     = mem[count[7:0] - 8'd1];
  assign rd_data = mem[rd_addr];

  // Every push enters an unvisited cell, so a full stack here means a walker bug.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && count == 9'd256));

endmodule

// File: rtl/maze_walker.sv
// rtl/maze_walker.sv - depth-first maze explorer with route replay
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start, show          search / replay request pulses
//   mem_dout             maze memory read data (1 = wall or visited)
//   mem_rd, mem_wr       memory read / write enables (never together)
//   mem_x, mem_y         memory cell address
//   mem_din              memory write data, always 1 (mark visited)
//   busy, done, fail     search status levels
//   move_valid, move     replayed route, one code per cycle
//   path_end             pulse after the last replayed move
module maze_walker
  import maze_pkg::*;
#(
  parameter logic [COORD_W-1:0] GOAL_X = 4'd15,
  parameter logic [COORD_W-1:0] GOAL_Y = 4'd15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               show,
  input  logic               mem_dout,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic [COORD_W-1:0] mem_x,
  output logic [COORD_W-1:0] mem_y,
  output logic               mem_din,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic               move_valid,
  output logic [1:0]         move,
  output logic               path_end
);

  walk_state_t        state, state_nxt;
  logic [COORD_W-1:0] pos_x, pos_y, pos_x_nxt, pos_y_nxt;
  logic [2:0]         dir, dir_nxt;   // value 4 means all candidates tried
  logic [SP_W-1:0]    rp, rp_nxt;     // replay index

  logic               push, pop, clear;
  logic [1:0]         top, rd_data;
  logic [SP_W-1:0]    sp;

  dir_t               step_dir;
  logic [COORD_W-1:0] nb_x, nb_y;
  logic               nb_ok;

  dir_stack u_stack (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (push),
    .pop       (pop),
    .push_data (dir[1:0]),
    .rd_addr   (rp[7:0]),
    .top       (top),
    .rd_data   (rd_data),
    .count     (sp)
  );

  assign mem_din = 1'b1;

  // Neighbour in the direction being probed/advanced, or back along the popped move.
  always_comb begin
    step_dir = (state == ST_BACKTRACK) ? opposite(dir_t'(top)) : dir_t'(dir[1:0]);
    nb_x  = pos_x;
    nb_y  = pos_y;
    nb_ok = 1'b0;
    case (step_dir)
      DIR_RIGHT: begin nb_x = pos_x + 4'd1; nb_ok = (pos_x != COORD_MAX); end
      DIR_DOWN:  begin nb_y = pos_y + 4'd1; nb_ok = (pos_y != COORD_MAX); end
      DIR_LEFT:  begin nb_x = pos_x - 4'd1; nb_ok = (pos_x != '0);        end
      DIR_UP:    begin nb_y = pos_y - 4'd1; nb_ok = (pos_y != '0);        end
      default:   begin nb_ok = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      pos_x <= '0;
      pos_y <= '0;
      dir   <= '0;
      rp    <= '0;
    end else begin
      state <= state_nxt;
      pos_x <= pos_x_nxt;
      pos_y <= pos_y_nxt;
      dir   <= dir_nxt;
      rp    <= rp_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pos_x_nxt  = pos_x;
    pos_y_nxt  = pos_y;
    dir_nxt    = dir;
    rp_nxt     = rp;
    push       = 1'b0;
    pop        = 1'b0;
    clear      = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_x      = pos_x;
    mem_y      = pos_y;
    busy       = 1'b0;
    done       = 1'b0;
    fail       = 1'b0;
    move_valid = 1'b0;
    move       = 2'd0;
    path_end   = 1'b0;

    case (state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        done = (state == ST_DONE);
        fail = (state == ST_FAIL);
        if (start) begin
          state_nxt = ST_MARK;
          pos_x_nxt = '0;
          pos_y_nxt = '0;
          dir_nxt   = '0;
          clear     = 1'b1;
        end else if (show && state == ST_DONE) begin
          state_nxt = ST_SHOW;
          rp_nxt    = '0;
        end
      end

      ST_MARK: begin
        busy      = 1'b1;
        mem_wr    = 1'b1;
        state_nxt = ST_PROBE;
      end

      ST_PROBE: begin
        busy = 1'b1;
        if (dir[2]) begin
          state_nxt = (sp == '0) ? ST_FAIL : ST_BACKTRACK;
        end else if (nb_ok) begin
          mem_rd = 1'b1;
          mem_x  = nb_x;
          mem_y  = nb_y;
          if (!mem_dout) begin
            state_nxt = ST_ADVANCE;
          end else begin
            dir_nxt = dir + 3'd1;
          end
        end else begin
          // Edge of the maze counts as a wall, without touching memory.
          dir_nxt = dir + 3'd1;
        end
      end

      ST_ADVANCE: begin
        busy      = 1'b1;
        push      = 1'b1;
        pos_x_nxt = nb_x;
        pos_y_nxt = nb_y;
        dir_nxt   = '0;
        state_nxt = (nb_x == GOAL_X && nb_y == GOAL_Y) ? ST_DONE : ST_MARK;
      end

      ST_BACKTRACK: begin
        busy      = 1'b1;
        pop       = 1'b1;
        pos_x_nxt = nb_x;
        pos_y_nxt = nb_y;
        if (top == 2'd3) begin
          // Nothing left to probe at the parent; keep unwinding.
          state_nxt = (sp == 9'd1) ? ST_FAIL : ST_BACKTRACK;
        end else begin
          dir_nxt   = {1'b0, top} + 3'd1;
          state_nxt = ST_PROBE;
        end
      end

      ST_SHOW: begin
        done = 1'b1;
        if (rp < sp) begin
          move_valid = 1'b1;
          move       = rd_data;
          rp_nxt     = rp + 9'd1;
        end else begin
          path_end  = 1'b1;
          state_nxt = ST_DONE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
